cam_window_capture: RTL and testbench

//  Parametrised camera capture engine: samples the 8-bit camera bus on clk
//  (camera xclk/pclk domain), pairs bytes into pixels, tracks x/y from

---
 rtl/cam_window_capture_if.sv | 27 ++
 rtl/cam_window_capture.sv | 224 ++++++++++++++++++++++
 tb/tb_cam_window_capture.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_window_capture_if.sv
// rtl/cam_window_capture_if.sv - camera bus, capture handshake and RAM read port bundle
interface cam_window_capture_if #(
    parameter int AW     = 8,
    parameter int DATA_W = 8
);
    logic              href;
    logic              vref;
    logic [7:0]        digital;
    logic              start;
    logic              busy;
    logic              done;
    logic              short_frame;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;

    // camera pins, arm pulse and read address come from the master side
    modport master (
        output href, vref, digital, start, rd_addr,
        input  busy, done, short_frame, rd_data
    );

    // capture engine side
    modport slave (
        input  href, vref, digital, start, rd_addr,
        output busy, done, short_frame, rd_data
    );
endinterface

// File: rtl/cam_window_capture.sv
// rtl/cam_window_capture.sv - camera byte-pair capture of a cropped, decimated window into RAM
module cam_window_capture #(
    parameter int WIN_W    = 15,
    parameter int WIN_H    = 15,
    parameter int X0       = 0,
    parameter int Y0       = 0,
    parameter int DECIM    = 1,
    parameter int DATA_W   = 8,
    parameter int BYTE_SEL = 0,
    parameter int AW       = $clog2(WIN_W * WIN_H)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cam_window_capture_if.slave  bus
);

    // x/y counters are wide enough for any realistic sensor and saturate
    localparam int CW  = 16;
    localparam int CW1 = CW + 1;
    // DECIM is restricted to 1, 2 or 4, so division is a shift
    localparam int DSH = (DECIM >= 4) ? 2 : ((DECIM >= 2) ? 1 : 0);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIN_W * WIN_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        CAPTURE,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic              href_q;
    logic              vref_q;
    logic              href_rise;
    logic              href_fall;
    logic              vref_rise;
    logic              vref_fall;
    logic              phase;
    logic              phase_eff;
    logic              pix_done;
    logic [7:0]        byte0;
    logic [CW-1:0]     x_cnt;
    logic [CW-1:0]     y_cnt;
    logic [CW:0]       x_diff;
    logic [CW:0]       y_diff;
    logic [CW-1:0]     x_off;
    logic [CW-1:0]     y_off;
    logic              x_hit;
    logic              y_hit;
    logic              win_hit;
    logic [AW-1:0]     col;
    logic [AW-1:0]     row;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              start_acc;
    logic              end_short;
    logic              short_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [0:(1 << AW) - 1];

    assign href_rise = bus.href & ~href_q;
    assign href_fall = ~bus.href & href_q;
    assign vref_rise = bus.vref & ~vref_q;
    assign vref_fall = ~bus.vref & vref_q;

    // a new line always begins on byte0, whatever the previous line left behind
    assign phase_eff = href_rise ? 1'b0 : phase;
    assign pix_done  = bus.href & phase_eff;

    // previous href/vref for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            href_q <= 1'b0;
            vref_q <= 1'b0;
        end else begin
            href_q <= bus.href;
            vref_q <= bus.vref;
        end
    end

    // byte pairing: hold byte0 until the second byte of the pixel arrives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= 1'b0;
            byte0 <= 8'd0;
        end else if (bus.href) begin
            phase <= ~phase_eff;
            if (!phase_eff) begin
                byte0 <= bus.digital;
            end
        end
    end

    // pixel column within the line; x_cnt is the column of the pixel completing now
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt <= '0;
        end else if (href_rise) begin
            x_cnt <= '0;
        end else if (pix_done && (x_cnt != '1)) begin
            x_cnt <= x_cnt + 1'b1;
        end
    end

    // line number within the frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_cnt <= '0;
        end else if (vref_fall) begin
            y_cnt <= '0;
        end else if (href_fall && (y_cnt != '1)) begin
            y_cnt <= y_cnt + 1'b1;
        end
    end

    // one extra bit so the borrow tells us the coordinate is left of / above the window
    assign x_diff = {1'b0, x_cnt} - CW1'(X0);
    assign y_diff = {1'b0, y_cnt} - CW1'(Y0);
    assign x_off  = x_diff[CW-1:0];
    assign y_off  = y_diff[CW-1:0];

    assign x_hit = ~x_diff[CW] && (x_off < CW'(WIN_W * DECIM)) &&
                   ((x_off & CW'(DECIM - 1)) == '0);
    assign y_hit = ~y_diff[CW] && (y_off < CW'(WIN_H * DECIM)) &&
                   ((y_off & CW'(DECIM - 1)) == '0);
    assign win_hit = x_hit & y_hit;

    assign col     = AW'(x_off >> DSH);
    assign row     = AW'(y_off >> DSH);
    assign wr_addr = row * AW'(WIN_W) + col;

    generate
        if (DATA_W == 16) begin : g_word
            assign wr_data = {byte0, bus.digital};
        end else begin : g_byte
            assign wr_data = (BYTE_SEL != 0) ? bus.digital : byte0;
        end
    endgenerate

    // capture state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state, RAM write enable and short-frame events
    always_comb begin
        state_nx  = state;
        wr_en     = 1'b0;
        start_acc = 1'b0;
        end_short = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx  = WAIT_FRAME;
                    start_acc = 1'b1;
                end
            end
            WAIT_FRAME: begin
                if (vref_fall) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                if (pix_done && win_hit) begin
                    wr_en = 1'b1;
                    if (wr_addr == LAST_ADDR) begin
                        state_nx = DONE;
                    end
                end
                // a frame end coinciding with the final write still counts as complete
                if (vref_rise && (state_nx != DONE)) begin
                    state_nx  = DONE;
                    end_short = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // sticky short-frame flag, cleared when a new capture is armed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            short_q <= 1'b0;
        end else if (start_acc) begin
            short_q <= 1'b0;
        end else if (end_short) begin
            short_q <= 1'b1;
        end
    end

    // window RAM write port; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // registered read port, returns old data on a same-address write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[bus.rd_addr];
        end
    end

    assign bus.busy        = (state == WAIT_FRAME) || (state == CAPTURE);
    assign bus.done        = (state == DONE);
    assign bus.short_frame = short_q;
    assign bus.rd_data     = rd_q;

endmodule

// File: tb/tb_cam_window_capture.sv
// tb/tb_cam_window_capture.sv - directed bench for cam_window_capture
module tb_cam_window_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        href;
    logic        vref;
    logic [7:0]  digital;
    logic        start_a;
    logic        start_b;
    logic [7:0]  rd_addr_a;
    logic [7:0]  rd_addr_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int done_cyc_a = 0;
    int mark_cyc = 0;
    logic busy_after_rst;

    cam_window_capture_if #(.AW(8), .DATA_W(8))  bus_a ();
    cam_window_capture_if #(.AW(8), .DATA_W(16)) bus_b ();

    assign bus_a.href    = href;
    assign bus_a.vref    = vref;
    assign bus_a.digital = digital;
    assign bus_a.start   = start_a;
    assign bus_a.rd_addr = rd_addr_a;
    assign bus_b.href    = href;
    assign bus_b.vref    = vref;
    assign bus_b.digital = digital;
    assign bus_b.start   = start_b;
    assign bus_b.rd_addr = rd_addr_b;

    cam_window_capture dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    cam_window_capture #(
        .X0     (4),
        .Y0     (2),
        .DECIM  (2),
        .DATA_W (16)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_a.done === 1'b1) begin
            done_cnt_a = done_cnt_a + 1;
            done_cyc_a = cyc;
        end
        if (bus_b.done === 1'b1) begin
            done_cnt_b = done_cnt_b + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input int addr, output logic [7:0] d);
        rd_addr_a = 8'(addr);
        @(posedge clk);
        @(negedge clk);
        d = bus_a.rd_data;
    endtask

    task automatic read_b(input int addr, output logic [15:0] d);
        rd_addr_b = 8'(addr);
        @(posedge clk);
        @(negedge clk);
        d = bus_b.rd_data;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    // pixel p = x + 16y + seed sent as bytes (p, ~p); odd lines add a trailing 0xEE
    task automatic drive_frame(input int npx, input int nlines, input bit odd, input int seed,
                               input int start_line, input int rst_line);
        int nbytes;
        nbytes = 2 * npx + (odd ? 1 : 0);
        href = 1'b0;
        vref = 1'b1;
        repeat (4) step();
        vref = 1'b0;
        repeat (3) step();
        for (int y = 0; y < nlines; y++) begin
            if (y == rst_line) begin
                reset_n = 1'b0;
                step();
                step();
                reset_n = 1'b1;
                step();
                busy_after_rst = bus_a.busy;
            end
            for (int b = 0; b < nbytes; b++) begin
                int x;
                logic [7:0] p;
                x = b / 2;
                p = 8'(x + 16 * y + seed);
                href = 1'b1;
                start_a = (y == start_line) && (b == 0);
                if (b == 2 * npx) digital = 8'hEE;
                else if (b[0]) digital = ~p;
                else digital = p;
                if (b[0] && x == 14 && y == 14) mark_cyc = cyc;
                step();
            end
            href = 1'b0;
            start_a = 1'b0;
            digital = 8'h00;
            repeat (4) step();
        end
        vref = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            href = i[0];
            digital = 8'(i * 37);
            start_a = 1'b1;
            start_b = 1'b1;
            step();
        end
        start_a = 1'b0;
        start_b = 1'b0;
        href = 1'b0;
        @(negedge clk);
        tests++;
        if (bus_a.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", bus_a.busy); end
        tests++;
        if (bus_a.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b want 0", bus_a.done); end
        tests++;
        if (bus_a.short_frame !== 1'b0) begin fails++; $display("FAIL reset_short: got %0b want 0", bus_a.short_frame); end
        tests++;
        if (bus_a.rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data_a: got %h want 00", bus_a.rd_data); end
        tests++;
        if (bus_b.rd_data !== 16'h0000) begin fails++; $display("FAIL reset_rd_data_b: got %h want 0000", bus_b.rd_data); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_full_capture();
        int base;
        logic [7:0] d;
        int addrs[5] = '{0, 14, 7 * 15 + 3, 14 * 15, 224};
        logic [7:0] exp[5] = '{8'd0, 8'd14, 8'd115, 8'd224, 8'd238};
        base = done_cnt_a;
        pulse_start_a();
        tests++;
        if (bus_a.busy !== 1'b1) begin fails++; $display("FAIL full_busy_after_start: got %0b want 1", bus_a.busy); end
        drive_frame(32, 20, 1'b0, 0, -1, -1);
        tests++;
        if (done_cnt_a - base != 1) begin fails++; $display("FAIL full_done_count: got %0d want 1", done_cnt_a - base); end
        tests++;
        if (done_cyc_a != mark_cyc + 1) begin fails++; $display("FAIL full_done_timing: got cycle %0d want %0d", done_cyc_a, mark_cyc + 1); end
        tests++;
        if (bus_a.short_frame !== 1'b0) begin fails++; $display("FAIL full_short: got %0b want 0", bus_a.short_frame); end
        tests++;
        if (bus_a.busy !== 1'b0) begin fails++; $display("FAIL full_busy_end: got %0b want 0", bus_a.busy); end
        for (int i = 0; i < 5; i++) begin
            read_a(addrs[i], d);
            tests++;
            if (d !== exp[i]) begin fails++; $display("FAIL full_ram[%0d]: got %0d want %0d", addrs[i], d, exp[i]); end
        end
    endtask

    task automatic test_mid_frame_start();
        int base;
        logic [7:0] d;
        base = done_cnt_a;
        drive_frame(32, 20, 1'b0, 8'h40, 5, -1);
        tests++;
        if (bus_a.busy !== 1'b1) begin fails++; $display("FAIL mid_busy_between_frames: got %0b want 1", bus_a.busy); end
        tests++;
        if (done_cnt_a != base) begin fails++; $display("FAIL mid_early_done: got %0d pulses want 0", done_cnt_a - base); end
        read_a(5 * 15, d);
        tests++;
        if (d !== 8'd80) begin fails++; $display("FAIL mid_no_partial_write: got %0d want 80", d); end
        drive_frame(32, 20, 1'b0, 8'h80, -1, -1);
        tests++;
        if (done_cnt_a - base != 1) begin fails++; $display("FAIL mid_done_count: got %0d want 1", done_cnt_a - base); end
        read_a(5 * 15, d);
        tests++;
        if (d !== 8'd208) begin fails++; $display("FAIL mid_ram75: got %0d want 208", d); end
        read_a(224, d);
        tests++;
        if (d !== 8'd110) begin fails++; $display("FAIL mid_ram224: got %0d want 110", d); end
    endtask

    task automatic test_window_decim();
        int base;
        logic [15:0] d;
        int addrs[4] = '{0, 1, 15, 224};
        logic [15:0] exp[4] = '{16'h24DB, 16'h26D9, 16'h44BB, 16'h00FF};
        base = done_cnt_b;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        drive_frame(40, 40, 1'b0, 0, -1, -1);
        tests++;
        if (done_cnt_b - base != 1) begin fails++; $display("FAIL win_done_count: got %0d want 1", done_cnt_b - base); end
        tests++;
        if (bus_b.short_frame !== 1'b0) begin fails++; $display("FAIL win_short: got %0b want 0", bus_b.short_frame); end
        for (int i = 0; i < 4; i++) begin
            read_b(addrs[i], d);
            tests++;
            if (d !== exp[i]) begin fails++; $display("FAIL win_ram[%0d]: got %h want %h", addrs[i], d, exp[i]); end
        end
    endtask

    task automatic test_short_frame();
        int base;
        logic [7:0] d;
        base = done_cnt_a;
        pulse_start_a();
        drive_frame(32, 10, 1'b0, 8'h10, -1, -1);
        tests++;
        if (done_cnt_a - base != 1) begin fails++; $display("FAIL short_done_count: got %0d want 1", done_cnt_a - base); end
        tests++;
        if (bus_a.short_frame !== 1'b1) begin fails++; $display("FAIL short_flag_set: got %0b want 1", bus_a.short_frame); end
        tests++;
        if (bus_a.busy !== 1'b0) begin fails++; $display("FAIL short_busy: got %0b want 0", bus_a.busy); end
        read_a(9 * 15 + 14, d);
        tests++;
        if (d !== 8'd174) begin fails++; $display("FAIL short_ram_row9: got %0d want 174", d); end
        read_a(10 * 15, d);
        tests++;
        if (d !== 8'd32) begin fails++; $display("FAIL short_ram_row10_kept: got %0d want 32", d); end
        pulse_start_a();
        tests++;
        if (bus_a.short_frame !== 1'b0) begin fails++; $display("FAIL short_clear_on_start: got %0b want 0", bus_a.short_frame); end
        drive_frame(32, 20, 1'b0, 8'h20, -1, -1);
        tests++;
        if (done_cnt_a - base != 2) begin fails++; $display("FAIL short_refill_done: got %0d want 2", done_cnt_a - base); end
        tests++;
        if (bus_a.short_frame !== 1'b0) begin fails++; $display("FAIL short_after_full: got %0b want 0", bus_a.short_frame); end
    endtask

    task automatic test_odd_bytes_reset();
        int base;
        logic [7:0] d;
        int addrs[4] = '{0, 14, 15, 224};
        logic [7:0] exp[4] = '{8'h50, 8'd94, 8'd96, 8'd62};
        base = done_cnt_a;
        pulse_start_a();
        drive_frame(15, 20, 1'b1, 8'h30, -1, 7);
        tests++;
        if (busy_after_rst !== 1'b0) begin fails++; $display("FAIL odd_busy_after_reset: got %0b want 0", busy_after_rst); end
        tests++;
        if (done_cnt_a != base) begin fails++; $display("FAIL odd_no_done_on_reset: got %0d pulses want 0", done_cnt_a - base); end
        tests++;
        if (bus_a.busy !== 1'b0) begin fails++; $display("FAIL odd_idle_after_frame: got %0b want 0", bus_a.busy); end
        pulse_start_a();
        drive_frame(15, 20, 1'b1, 8'h50, -1, -1);
        tests++;
        if (done_cnt_a - base != 1) begin fails++; $display("FAIL odd_recapture_done: got %0d want 1", done_cnt_a - base); end
        for (int i = 0; i < 4; i++) begin
            read_a(addrs[i], d);
            tests++;
            if (d !== exp[i]) begin fails++; $display("FAIL odd_ram[%0d]: got %0d want %0d", addrs[i], d, exp[i]); end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        href      = 1'b0;
        vref      = 1'b1;
        digital   = 8'h00;
        start_a   = 1'b0;
        start_b   = 1'b0;
        rd_addr_a = 8'h00;
        rd_addr_b = 8'h00;
        busy_after_rst = 1'b1;
        test_reset();
        test_full_capture();
        test_mid_frame_start();
        test_window_decim();
        test_short_frame();
        test_odd_bytes_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
